mioc_dram_timing: RTL

DRAM strobe sequencer for the MIOC. Converts buffered Z80 memory-request, read/write and refresh signals into the multiplexed DRAM controls (RAS_N, CAS1_N, CAS2_N, MUX, RA7) that mioc_top drives on pins 2 and 37–40. It sits between the MIOC address decode, which supplies RAMEN, and the DRAM pins. It is clocked from B_PHI.

---
 rtl/mioc_dram_timing.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mioc_dram_timing.sv
// DRAM strobe sequencer: turns buffered Z80 MREQ/RD/WR/RFSH into registered RAS/CAS/MUX/RA7.
// Strobes are derived from the current state and registered, so they trail the state by one edge.
module mioc_dram_timing #(
    parameter int TIMEOUT = 15,
    parameter int PRE_CYC = 1
) (
    input  logic       B_PHI,
    input  logic       RST,
    input  logic       BMREQ_N,
    input  logic       BRFSH_N,
    input  logic       BRD_N,
    input  logic       N_BWR,
    input  logic       BA15,
    input  logic       BA14,
    input  logic       BA6,
    input  logic       RAMEN,
    output logic       RAS_N,
    output logic       CAS1_N,
    output logic       CAS2_N,
    output logic       MUX,
    output logic       RA7,
    output logic [7:0] REF_CNT,
    output logic       TMO,
    output logic [2:0] DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RAS  = 3'd1,
        S_MUXD = 3'd2,
        S_CAS  = 3'd3,
        S_REFH = 3'd4,
        S_PRE  = 3'd5
    } state_t;

    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
    localparam logic [1:0] PRE_LAST = 2'(PRE_CYC - 1);

    state_t     state_q, state_d;
    logic       is_ref_q, is_ref_d;
    logic       bank_q, bank_d;
    logic       lock_q, lock_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic [1:0] pcnt_q, pcnt_d;
    logic [7:0] ref_cnt_q, ref_cnt_d;
    logic       start, tmo_hit, ref_done;
    logic       ras_n_d, cas1_n_d, cas2_n_d, mux_d, ra7_d, tmo_d;
    logic       ras_n_q, cas1_n_q, cas2_n_q, mux_q, ra7_q, tmo_q;

    assign start = !BMREQ_N && (!BRFSH_N || (RAMEN && (!BRD_N || !N_BWR)));

    always_ff @(posedge B_PHI) begin
        if (RST) begin
            state_q   <= S_IDLE;
            is_ref_q  <= 1'b0;
            bank_q    <= 1'b0;
            lock_q    <= 1'b0;
            tcnt_q    <= '0;
            pcnt_q    <= '0;
            ref_cnt_q <= '0;
            ras_n_q   <= 1'b1;
            cas1_n_q  <= 1'b1;
            cas2_n_q  <= 1'b1;
            mux_q     <= 1'b0;
            ra7_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_ref_q  <= is_ref_d;
            bank_q    <= bank_d;
            lock_q    <= lock_d;
            tcnt_q    <= tcnt_d;
            pcnt_q    <= pcnt_d;
            ref_cnt_q <= ref_cnt_d;
            ras_n_q   <= ras_n_d;
            cas1_n_q  <= cas1_n_d;
            cas2_n_q  <= cas2_n_d;
            mux_q     <= mux_d;
            ra7_q     <= ra7_d;
            tmo_q     <= tmo_d;
        end
    end

    // A normal end of cycle (MREQ/RFSH released) wins over a timeout on the same edge.
    always_comb begin
        state_d  = state_q;
        is_ref_d = is_ref_q;
        bank_d   = bank_q;
        tmo_hit  = 1'b0;
        ref_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !lock_q) begin
                    state_d  = S_RAS;
                    is_ref_d = !BRFSH_N;
                    bank_d   = BA15;
                end
            end
            S_RAS: begin
                if (BMREQ_N)       state_d = S_PRE;
                else if (is_ref_q) state_d = S_REFH;
                else               state_d = S_MUXD;
            end
            S_MUXD: state_d = BMREQ_N ? S_PRE : S_CAS;
            S_CAS: begin
                if (BMREQ_N) begin
                    state_d = S_PRE;
                end else if (tcnt_q == TMO_LAST) begin
                    state_d = S_PRE;
                    tmo_hit = 1'b1;
                end
            end
            S_REFH: begin
                if (BMREQ_N || BRFSH_N) begin
                    state_d  = S_PRE;
                    ref_done = 1'b1;
                end else if (tcnt_q == TMO_LAST) begin
                    state_d = S_PRE;
                    tmo_hit = 1'b1;
                end
            end
            S_PRE: if (pcnt_q == PRE_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        tcnt_d = ((state_q == S_CAS || state_q == S_REFH) && state_d == state_q) ? tcnt_q + 4'd1 : 4'd0;
        pcnt_d = (state_q == S_PRE && state_d == S_PRE) ? pcnt_q + 2'd1 : 2'd0;
        // After a timeout, hold off new starts until the CPU releases MREQ.
        lock_d    = tmo_hit ? 1'b1 : (BMREQ_N ? 1'b0 : lock_q);
        ref_cnt_d = ref_cnt_q + {7'd0, ref_done};
    end

    always_comb begin
        ras_n_d  = !(state_q == S_RAS || state_q == S_MUXD || state_q == S_CAS || state_q == S_REFH);
        mux_d    = (state_q == S_MUXD || state_q == S_CAS);
        cas1_n_d = !(state_q == S_CAS && !bank_q);
        cas2_n_d = !(state_q == S_CAS && bank_q);
        ra7_d    = mux_d ? BA14 : BA6;
        tmo_d    = tmo_hit;
    end

    assign RAS_N     = ras_n_q;
    assign CAS1_N    = cas1_n_q;
    assign CAS2_N    = cas2_n_q;
    assign MUX       = mux_q;
    assign RA7       = ra7_q;
    assign REF_CNT   = ref_cnt_q;
    assign TMO       = tmo_q;
    assign DBG_STATE = state_q;

endmodule
